// File: rtl/gio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : gio_debounce
//  Purpose  : Per-pin synchroniser and glitch filter in front of the GIO
//             input ports. Sample period and per-pin bypass are programmable
//             from the Pacoblaze port bus (write-only).
//  Revision : 1.0  initial release
// ============================================================================
module gio_debounce #(
   parameter int         WIDTH          = 4,
   parameter logic [7:0] ADDR_PERIOD    = 8'h10,
   parameter logic [7:0] ADDR_BYPASS    = 8'h11,
   parameter logic [7:0] DEFAULT_PERIOD = 8'd99,
   parameter int         STABLE_TICKS   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] pins_out,
   output logic [WIDTH-1:0] changed,
   input  logic [7:0]       address,
   input  logic [7:0]       value_in,
   input  logic             wen
);

   // A single matching tick can never qualify a new level, so the filter
   // depth is never allowed below two ticks.
   localparam int c_ticks = (STABLE_TICKS < 2) ? 2 : STABLE_TICKS;
   localparam int c_cnt_w = $clog2(c_ticks);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_ticks - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   localparam logic [0:0] c_stable  = 1'b0;
   localparam logic [0:0] c_pending = 1'b1;

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [7:0]       r_period;
   logic [WIDTH-1:0] r_bypass;
   logic [7:0]       r_presc;
   logic             w_tick;
   logic             w_wr_period;
   logic             w_wr_bypass;
   logic             w_unused_value;

   assign w_wr_period    = wen && (address == ADDR_PERIOD);
   assign w_wr_bypass    = wen && (address == ADDR_BYPASS);
   assign w_tick         = (r_presc == r_period);
   // Upper data bits are meaningless for narrow instances.
   assign w_unused_value = ^value_in;

   // Two-flop synchroniser for every raw pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pins_in;
         r_sync2 <= r_sync1;
      end
   end

   // Port-bus writes to the period and bypass registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period <= DEFAULT_PERIOD;
         r_bypass <= '0;
      end else begin
         if (w_wr_period) r_period <= value_in;
         if (w_wr_bypass) r_bypass <= value_in[WIDTH-1:0];
      end
   end

   // Sample prescaler: ticks once every period+1 cycles; restarted by a
   // period write so the new period takes effect from the write edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_wr_period || w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 8'd1;
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         logic [0:0]         r_state;
         logic [c_cnt_w-1:0] r_cnt;
         logic               r_level;
         logic               r_chg;
         logic               w_mismatch;

         assign w_mismatch  = r_sync2[i] ^ r_level;
         assign pins_out[i] = r_level;
         assign changed[i]  = r_chg;

         // Per-pin filter: a new level is accepted only after it has been
         // seen on c_ticks consecutive sample ticks with no matching cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state <= c_stable;
               r_cnt   <= '0;
               r_level <= 1'b0;
               r_chg   <= 1'b0;
            end else begin
               r_chg <= 1'b0;
               if (r_bypass[i]) begin
                  r_level <= r_sync2[i];
                  r_chg   <= w_mismatch;
                  r_state <= c_stable;
                  r_cnt   <= '0;
               end else begin
                  case (r_state)
                     c_stable: begin
                        if (w_mismatch && w_tick) begin
                           r_state <= c_pending;
                           r_cnt   <= c_cnt_one;
                        end
                     end
                     c_pending: begin
                        if (!w_mismatch) begin
                           r_state <= c_stable;
                           r_cnt   <= '0;
                        end else if (w_tick) begin
                           if (r_cnt == c_cnt_last) begin
                              r_level <= r_sync2[i];
                              r_chg   <= 1'b1;
                              r_state <= c_stable;
                              r_cnt   <= '0;
                           end else begin
                              r_cnt <= r_cnt + c_cnt_one;
                           end
                        end
                     end
                     default: begin
                        r_state <= c_stable;
                        r_cnt   <= '0;
                     end
                  endcase
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gio_debounce
//  Purpose  : Self-checking bench for gio_debounce against a cycle-counting
//             reference model (run-length of mismatching ticks per pin).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gio_debounce;

   localparam int c_w  = 4;
   localparam int c_st = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [c_w-1:0] pins_in;
   logic [c_w-1:0] pins_out;
   logic [c_w-1:0] changed;
   logic [7:0]     address;
   logic [7:0]     value_in;
   logic           wen;

   gio_debounce #(
      .WIDTH          (c_w),
      .ADDR_PERIOD    (8'h10),
      .ADDR_BYPASS    (8'h11),
      .DEFAULT_PERIOD (8'd99),
      .STABLE_TICKS   (c_st)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pins_in  (pins_in),
      .pins_out (pins_out),
      .changed  (changed),
      .address  (address),
      .value_in (value_in),
      .wen      (wen)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [c_w-1:0] m_s1, m_s2, m_out, m_chg, m_byp;
   int             m_period;
   int             m_since;
   int             m_run [c_w];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_out = '0; m_chg = '0; m_byp = '0;
      m_period = 99;
      m_since  = 0;
      for (int i = 0; i < c_w; i++) m_run[i] = 0;
   endtask

   // Advance model and DUT by one clock edge, then compare outputs.
   task automatic step();
      bit             tick;
      logic [c_w-1:0] n_out;
      logic [c_w-1:0] n_chg;
      tick  = (m_since % (m_period + 1)) == m_period;
      n_out = m_out;
      n_chg = '0;
      for (int i = 0; i < c_w; i++) begin
         if (m_byp[i]) begin
            n_out[i] = m_s2[i];
            n_chg[i] = m_s2[i] != m_out[i];
            m_run[i] = 0;
         end else if (m_s2[i] == m_out[i]) begin
            m_run[i] = 0;
         end else if (tick) begin
            m_run[i]++;
            if (m_run[i] == c_st) begin
               n_out[i] = m_s2[i];
               n_chg[i] = 1'b1;
               m_run[i] = 0;
            end
         end
      end
      m_out = n_out;
      m_chg = n_chg;
      if (wen && address == 8'h10) begin
         m_period = int'(value_in);
         m_since  = 0;
      end else begin
         m_since++;
      end
      if (wen && address == 8'h11) m_byp = value_in[c_w-1:0];
      m_s2 = m_s1;
      m_s1 = pins_in;
      @(posedge clk);
      #1;
      check("pins_out", 32'(pins_out), 32'(m_out));
      check("changed",  32'(changed),  32'(m_chg));
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [7:0] v);
      address  = a;
      value_in = v;
      wen      = 1'b1;
      step();
      wen      = 1'b0;
      address  = 8'h00;
      value_in = 8'h00;
   endtask

   initial begin
      int k;
      int b;
      int r;
      int pulses;

      // ---- 1. reset ----
      pins_in = '0; address = '0; value_in = '0; wen = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_pins_out", 32'(pins_out), 32'h0);
      check("reset_changed",  32'(changed),  32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 50; c++) step();

      // ---- 2. period 0, bit 0 rises: output on 5th edge ----
      write_reg(8'h10, 8'h00);
      pins_in[0] = 1'b1;
      for (int c = 0; c < 4; c++) step();
      check("lat5_before", 32'(pins_out[0]), 32'h0);
      step();
      check("lat5_level",  32'(pins_out[0]), 32'h1);
      check("lat5_pulse",  32'(changed), 32'h1);
      step();
      check("lat5_pulse_end", 32'(changed), 32'h0);

      // ---- 3. two-cycle glitch on bit 1 rejected ----
      pins_in[1] = 1'b1;
      step(); step();
      pins_in[1] = 1'b0;
      for (int c = 0; c < 10; c++) step();
      check("glitch2_level", 32'(pins_out[1]), 32'h0);

      // ---- 4. period 4: latency window and 7-cycle glitch ----
      write_reg(8'h10, 8'h04);
      r = $urandom_range(0, 4);
      for (int c = 0; c < r; c++) step();
      pins_in[2] = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (pins_out[2] !== 1'b1 && k < 30);
      // first usable tick lands on edge 3..7, two more ticks 10 edges later
      check("p4_latency_window", 32'(k >= 13 && k <= 17), 32'h1);
      for (int c = 0; c < 6; c++) step();
      pins_in[2] = 1'b0;
      for (int c = 0; c < 7; c++) step();
      pins_in[2] = 1'b1;
      for (int c = 0; c < 20; c++) step();
      check("glitch7_level", 32'(pins_out[2]), 32'h1);

      // ---- 5. bypass bit 3 ----
      write_reg(8'h11, 8'h08);
      pulses = 0;
      for (int t = 0; t < 3; t++) begin
         pins_in[3] = (t % 2 == 0);
         for (int c = 0; c < 3; c++) begin
            step();
            if (changed[3]) pulses++;
         end
      end
      for (int c = 0; c < 5; c++) begin
         step();
         if (changed[3]) pulses++;
      end
      check("bypass_pulses", 32'(pulses), 32'd3);

      // ---- 6. async reset while bit 0 is pending ----
      write_reg(8'h10, 8'h00);
      pins_in = 4'hF;
      for (int c = 0; c < 8; c++) step();
      check("all_high", 32'(pins_out), 32'hF);
      pins_in[0] = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      #1;
      check("async_rst_pins_out", 32'(pins_out), 32'h0);
      check("async_rst_changed",  32'(changed),  32'h0);
      model_reset();
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      pins_in = 4'hE;
      k = 0;
      do begin
         step();
         k++;
      end while (pins_out !== 4'hE && k < 400);
      // default period 99: ticks on edges 100, 200, 300 after release
      check("default_period_latency", 32'(k), 32'd300);

      // ---- 7. randomized traffic ----
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, c_w - 1);
            pins_in[b] = ~pins_in[b];
         end
         r = $urandom_range(0, 99);
         if (r < 3) begin
            address = 8'h10; value_in = 8'($urandom_range(0, 3)); wen = 1'b1;
         end else if (r < 5) begin
            address = 8'h11; value_in = 8'($urandom); wen = 1'b1;
         end else if (r < 7) begin
            address = 8'($urandom); value_in = 8'($urandom); wen = 1'b1;
         end else begin
            address = 8'h00; value_in = 8'h00; wen = 1'b0;
         end
         step();
      end
      wen = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
